// File: rtl/coh_dcache_agent_pkg.sv
// Shared types for the MSI data-cache coherence agent.
package coh_dcache_agent_pkg;

  localparam int unsigned DIDX_W = 4;
  localparam int unsigned DTAG_W = 26;
  localparam int unsigned DSETS  = 1 << DIDX_W;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    SNOOP_WB,
    EVICT,
    FETCH
  } coh_agent_state_t;

  typedef struct packed {
    msi_t              msi;
    logic [DTAG_W-1:0] tag;
    logic [31:0]       data;
  } coh_frame_t;

  // A frame holds the block when it is valid and the tags agree.
  function automatic logic frame_hit(input msi_t msi, input logic [DTAG_W-1:0] frame_tag,
                                     input logic [DTAG_W-1:0] req_tag);
    return (msi != MSI_I) && (frame_tag == req_tag);
  endfunction

endpackage

// File: rtl/coh_dcache_agent_if.sv
// Datapath dmem port plus the cache_control_if slot of one core.
interface coh_dcache_agent_if;

  // datapath side
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dhit;

  // memory / coherence controller side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        cctrans;
  logic        ccwrite;
  logic        ccwait;
  logic [31:0] ccsnoopaddr;
  logic        ccinv;

  // The cache agent.
  modport master (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccsnoopaddr, ccinv,
    output dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

  // Datapath and memory_control seen together.
  modport slave (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dload, dwait, ccwait, ccsnoopaddr, ccinv,
    input  dmemload, dhit, dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

endinterface

// File: rtl/coh_dcache_agent_frame_array.sv
// 16-entry frame store: one datapath lookup port, one snoop lookup port, one write port.
module coh_dcache_agent_frame_array
  import coh_dcache_agent_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DIDX_W-1:0] ridx,
  output coh_frame_t        rframe,
  input  logic [DIDX_W-1:0] sidx,
  output coh_frame_t        sframe,
  input  logic              wen,
  input  logic [DIDX_W-1:0] widx,
  input  coh_frame_t        wframe
);

  coh_frame_t frames [DSETS];

  // Reset invalidates every block (dirty data is dropped); otherwise single write port.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(DSETS); i++) begin
        frames[i] <= '{msi: MSI_I, tag: '0, data: '0};
      end
    end else if (wen) begin
      frames[widx] <= wframe;
    end
  end

  assign rframe = frames[ridx];
  assign sframe = frames[sidx];

endmodule

// File: rtl/coh_dcache_agent.sv
// MSI coherence agent for one core's direct-mapped, one-word-block data cache.
module coh_dcache_agent
  import coh_dcache_agent_pkg::*;
#(
  parameter int unsigned CPUID = 0
) (
  input logic                CLK,
  input logic                nRST,
  coh_dcache_agent_if.master bus
);

  if (CPUID > 1) begin : g_cpuid_check
    $error("coh_dcache_agent: CPUID must select slot 0 or 1");
  end

  coh_agent_state_t state_q, state_d;
  logic             inv_q, inv_d;

  logic [DIDX_W-1:0] ridx, sidx, widx;
  logic [DTAG_W-1:0] rtag, stag;
  coh_frame_t        rframe, sframe, wframe;
  logic              wen;
  logic              req_hit, snp_hit;

  assign ridx = bus.dmemaddr[2 +: DIDX_W];
  assign rtag = bus.dmemaddr[31 -: DTAG_W];
  assign sidx = bus.ccsnoopaddr[2 +: DIDX_W];
  assign stag = bus.ccsnoopaddr[31 -: DTAG_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dmemaddr[1:0], bus.ccsnoopaddr[1:0]};

  assign req_hit = frame_hit(rframe.msi, rframe.tag, rtag);
  assign snp_hit = frame_hit(sframe.msi, sframe.tag, stag);

  coh_dcache_agent_frame_array u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .ridx   (ridx),
    .rframe (rframe),
    .sidx   (sidx),
    .sframe (sframe),
    .wen    (wen),
    .widx   (widx),
    .wframe (wframe)
  );

  // State and captured snoop-invalidate flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
    end
  end

  // Next state, frame updates and bus outputs.
  always_comb begin
    state_d      = state_q;
    inv_d        = inv_q;
    wen          = 1'b0;
    widx         = ridx;
    wframe       = rframe;
    bus.dhit     = 1'b0;
    bus.dmemload = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.cctrans  = 1'b0;
    bus.ccwrite  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A pending snoop always beats the local request.
        if (bus.ccwait) begin
          state_d = SNOOP;
          inv_d   = bus.ccinv;
        end else if (bus.dmemREN && req_hit) begin
          bus.dhit     = 1'b1;
          bus.dmemload = rframe.data;
        end else if (bus.dmemWEN && req_hit && (rframe.msi == MSI_M)) begin
          bus.dhit    = 1'b1;
          wen         = 1'b1;
          wframe.data = bus.dmemstore;
        end else if (bus.dmemREN || bus.dmemWEN) begin
          // Only a dirty block of a different address needs writing back first.
          state_d = ((rframe.msi == MSI_M) && (rframe.tag != rtag)) ? EVICT : FETCH;
        end
      end

      EVICT: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {rframe.tag, ridx, 2'b00};
        bus.dstore = rframe.data;
        if (!bus.dwait) begin
          wen        = 1'b1;
          wframe.msi = MSI_I;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        bus.cctrans = 1'b1;
        bus.ccwrite = bus.dmemWEN;
        bus.dREN    = 1'b1;
        bus.daddr   = bus.dmemaddr;
        if (!bus.dwait) begin
          wen         = 1'b1;
          wframe.msi  = bus.dmemWEN ? MSI_M : MSI_S;
          wframe.tag  = rtag;
          wframe.data = bus.dmemWEN ? bus.dmemstore : bus.dload;
          state_d     = IDLE;
        end
      end

      SNOOP: begin
        widx   = sidx;
        wframe = sframe;
        if (snp_hit && (sframe.msi == MSI_M)) begin
          state_d = SNOOP_WB;
        end else begin
          state_d = IDLE;
          if (snp_hit && inv_q) begin
            wen        = 1'b1;
            wframe.msi = MSI_I;
          end
        end
      end

      SNOOP_WB: begin
        widx       = sidx;
        wframe     = sframe;
        bus.dWEN   = 1'b1;
        bus.daddr  = bus.ccsnoopaddr;
        bus.dstore = sframe.data;
        if (!bus.dwait) begin
          wen        = 1'b1;
          wframe.msi = inv_q ? MSI_I : MSI_S;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coh_dcache_agent.sv
// Directed bench for coh_dcache_agent: misses, upgrades, evictions, snoops and reset.
module tb_coh_dcache_agent;

  logic clk = 1'b0;
  logic nrst;
  int   passed = 0;
  int   total  = 0;

  coh_dcache_agent_if bus ();

  coh_dcache_agent #(.CPUID(0)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    nrst = 1'b0;
    bus.dmemREN = 1'b1; bus.dmemWEN = 1'b0; bus.dmemaddr = 32'h100; bus.dmemstore = '0;
    bus.dload = '0; bus.dwait = 1'b1; bus.ccwait = 1'b0; bus.ccsnoopaddr = '0; bus.ccinv = 1'b0;
    @(negedge clk); #1;
    total++; if ({bus.dhit, bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
               {bus.dhit, bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite}); else passed++;
    total++; if ({bus.daddr, bus.dstore, bus.dmemload} !== 96'h0)
      $display("FAIL reset_data got %h want 0", {bus.daddr, bus.dstore, bus.dmemload});
    else passed++;
    bus.dmemREN = 1'b0;
    @(negedge clk); nrst = 1'b1;
  endtask

  task automatic test_read_miss();
    @(negedge clk); bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; bus.dwait = 1'b1; #1;
    total++; if ({bus.dhit, bus.dREN} !== 2'b00)
      $display("FAIL rd_miss_idle got %b want 00", {bus.dhit, bus.dREN}); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.cctrans, bus.ccwrite, bus.dREN, bus.dWEN, bus.dhit} !== 5'b10100)
      $display("FAIL rd_fetch_ctl got %b want 10100",
               {bus.cctrans, bus.ccwrite, bus.dREN, bus.dWEN, bus.dhit}); else passed++;
    total++; if (bus.daddr !== 32'h100)
      $display("FAIL rd_fetch_addr got %h want 00000100", bus.daddr); else passed++;
    @(negedge clk); #1;
    total++; if (bus.dREN !== 1'b1)
      $display("FAIL rd_fetch_hold got %b want 1", bus.dREN); else passed++;
    bus.dwait = 1'b0; bus.dload = 32'hCAFE0001;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if ({bus.dhit, bus.dREN, bus.cctrans} !== 3'b100)
      $display("FAIL rd_fill_ctl got %b want 100", {bus.dhit, bus.dREN, bus.cctrans});
    else passed++;
    total++; if (bus.dmemload !== 32'hCAFE0001)
      $display("FAIL rd_fill_data got %h want cafe0001", bus.dmemload); else passed++;
    bus.dmemREN = 1'b0;
  endtask

  task automatic test_store_upgrade();
    @(negedge clk); bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'hDEAD; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL st_s_nohit got %b want 0", bus.dhit); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.cctrans, bus.ccwrite, bus.dREN} !== 3'b111)
      $display("FAIL st_busrdx got %b want 111", {bus.cctrans, bus.ccwrite, bus.dREN});
    else passed++;
    bus.dwait = 1'b0; bus.dload = 32'hCAFE0001;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if (bus.dhit !== 1'b1)
      $display("FAIL st_m_hit got %b want 1", bus.dhit); else passed++;
    bus.dmemWEN = 1'b0; bus.dmemREN = 1'b1; #1;
    total++; if ({bus.dhit, bus.dmemload} !== {1'b1, 32'hDEAD})
      $display("FAIL st_readback got %b/%h want 1/0000dead", bus.dhit, bus.dmemload);
    else passed++;
    bus.dmemREN = 1'b0;
  endtask

  task automatic test_evict();
    @(negedge clk); bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h140; bus.dmemstore = 32'hBEEF; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL ev_miss got %b want 0", bus.dhit); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.dWEN, bus.dREN, bus.cctrans} !== 3'b100)
      $display("FAIL ev_ctl got %b want 100", {bus.dWEN, bus.dREN, bus.cctrans}); else passed++;
    total++; if ({bus.daddr, bus.dstore} !== {32'h100, 32'hDEAD})
      $display("FAIL ev_wb got %h/%h want 00000100/0000dead", bus.daddr, bus.dstore);
    else passed++;
    bus.dwait = 1'b0;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if ({bus.dWEN, bus.dREN, bus.ccwrite, bus.daddr} !== {3'b011, 32'h140})
      $display("FAIL ev_fetch got %b/%h want 011/00000140",
               {bus.dWEN, bus.dREN, bus.ccwrite}, bus.daddr); else passed++;
    bus.dwait = 1'b0; bus.dload = 32'h0;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if (bus.dhit !== 1'b1)
      $display("FAIL ev_done_hit got %b want 1", bus.dhit); else passed++;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic test_back_to_back();
    // 0x140 is dirty with 0xBEEF; storing 0x100 evicts it straight into the next fetch.
    @(negedge clk); bus.dmemWEN = 1'b1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'hDEAD;
    @(negedge clk); #1;
    total++; if ({bus.dWEN, bus.daddr, bus.dstore} !== {1'b1, 32'h140, 32'hBEEF})
      $display("FAIL b2b_evict got %b/%h/%h want 1/00000140/0000beef",
               bus.dWEN, bus.daddr, bus.dstore); else passed++;
    bus.dwait = 1'b0; bus.dload = 32'h0;
    @(negedge clk); #1;
    total++; if ({bus.dREN, bus.dWEN, bus.daddr} !== {2'b10, 32'h100})
      $display("FAIL b2b_fetch got %b/%h want 10/00000100", {bus.dREN, bus.dWEN}, bus.daddr);
    else passed++;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if (bus.dhit !== 1'b1)
      $display("FAIL b2b_hit got %b want 1", bus.dhit); else passed++;
    bus.dmemWEN = 1'b0;
  endtask

  task automatic test_snoop_wb();
    // Snoop M line without invalidate, with a competing local read of the same block.
    @(negedge clk); bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h100; bus.ccinv = 1'b0;
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; #1;
    total++; if ({bus.dhit, bus.dWEN} !== 2'b00)
      $display("FAIL snp_prio got %b want 00", {bus.dhit, bus.dWEN}); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.dhit, bus.dWEN} !== 2'b00)
      $display("FAIL snp_lookup got %b want 00", {bus.dhit, bus.dWEN}); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.dhit, bus.dWEN, bus.daddr, bus.dstore} !== {2'b01, 32'h100, 32'hDEAD})
      $display("FAIL snp_wb got %b/%h/%h want 01/00000100/0000dead",
               {bus.dhit, bus.dWEN}, bus.daddr, bus.dstore); else passed++;
    bus.ccwait = 1'b0; bus.dwait = 1'b0;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if ({bus.dhit, bus.dWEN, bus.dmemload} !== {2'b10, 32'hDEAD})
      $display("FAIL snp_after_rd got %b/%h want 10/0000dead",
               {bus.dhit, bus.dWEN}, bus.dmemload); else passed++;
    bus.dmemREN = 1'b0; bus.dmemWEN = 1'b1; bus.dmemstore = 32'h1234; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL snp_left_s got %b want 0", bus.dhit); else passed++;
    // Upgrade back to M with 0x1234.
    @(negedge clk); #1;
    total++; if ({bus.cctrans, bus.ccwrite} !== 2'b11)
      $display("FAIL snp_upgrade got %b want 11", {bus.cctrans, bus.ccwrite}); else passed++;
    bus.dwait = 1'b0;
    @(negedge clk); bus.dwait = 1'b1; bus.dmemWEN = 1'b0;
    // Snoop with invalidate; ccinv drops after entry and must be ignored.
    @(negedge clk); bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h100; bus.ccinv = 1'b1;
    @(negedge clk); bus.ccinv = 1'b0;
    @(negedge clk); #1;
    total++; if ({bus.dWEN, bus.dstore} !== {1'b1, 32'h1234})
      $display("FAIL snpinv_wb got %b/%h want 1/00001234", bus.dWEN, bus.dstore); else passed++;
    bus.ccwait = 1'b0; bus.dwait = 1'b0;
    @(negedge clk); bus.dwait = 1'b1; bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL snpinv_miss got %b want 0", bus.dhit); else passed++;
    @(negedge clk); #1;
    total++; if (bus.dREN !== 1'b1)
      $display("FAIL snpinv_refetch got %b want 1", bus.dREN); else passed++;
    bus.dwait = 1'b0; bus.dload = 32'h5555;
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if ({bus.dhit, bus.dmemload} !== {1'b1, 32'h5555})
      $display("FAIL snpinv_fill got %b/%h want 1/00005555", bus.dhit, bus.dmemload);
    else passed++;
    bus.dmemREN = 1'b0;
  endtask

  task automatic test_snoop_nosupply();
    // Snoop miss: no dWEN anywhere in the window, S line untouched.
    @(negedge clk); bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h200; bus.ccinv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.ccwait = 1'b0; #1;
      total++; if (bus.dWEN !== 1'b0)
        $display("FAIL nosup_miss[%0d] dWEN got %b want 0", i, bus.dWEN); else passed++;
    end
    bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; #1;
    total++; if (bus.dhit !== 1'b1)
      $display("FAIL nosup_keep_s got %b want 1", bus.dhit); else passed++;
    bus.dmemREN = 1'b0;
    // Snoop S line with invalidate: still no supply, line goes I.
    @(negedge clk); bus.ccwait = 1'b1; bus.ccsnoopaddr = 32'h100; bus.ccinv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.ccwait = 1'b0; #1;
      total++; if (bus.dWEN !== 1'b0)
        $display("FAIL nosup_s[%0d] dWEN got %b want 0", i, bus.dWEN); else passed++;
    end
    bus.dmemREN = 1'b1; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL nosup_s_inv got %b want 0", bus.dhit); else passed++;
    bus.dmemREN = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.dmemREN = 1'b1; bus.dmemaddr = 32'h100; bus.dwait = 1'b0;
    bus.dload = 32'h77;
    @(negedge clk);
    @(negedge clk); bus.dwait = 1'b1; #1;
    total++; if ({bus.dhit, bus.dmemload} !== {1'b1, 32'h77})
      $display("FAIL rst_pre_hit got %b/%h want 1/00000077", bus.dhit, bus.dmemload);
    else passed++;
    bus.dmemaddr = 32'h140;
    @(negedge clk); #1;
    total++; if ({bus.dREN, bus.daddr} !== {1'b1, 32'h140})
      $display("FAIL rst_in_fetch got %b/%h want 1/00000140", bus.dREN, bus.daddr);
    else passed++;
    nrst = 1'b0; #1;
    total++; if ({bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite, bus.dhit, bus.daddr} !== 37'h0)
      $display("FAIL rst_mid_outs got %b/%h want 00000/00000000",
               {bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite, bus.dhit}, bus.daddr);
    else passed++;
    @(negedge clk); nrst = 1'b1; bus.dmemaddr = 32'h100; #1;
    total++; if (bus.dhit !== 1'b0)
      $display("FAIL rst_lost_line got %b want 0", bus.dhit); else passed++;
    @(negedge clk); #1;
    total++; if ({bus.dREN, bus.daddr} !== {1'b1, 32'h100})
      $display("FAIL rst_refetch got %b/%h want 1/00000100", bus.dREN, bus.daddr);
    else passed++;
    bus.dmemREN = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_store_upgrade();
    test_evict();
    test_back_to_back();
    test_snoop_wb();
    test_snoop_nosupply();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/coh_dcache_agent.md
# coh_dcache_agent

Cache-side coherence agent for one core of the dual-core MSI system: a 16-set direct-mapped, one-word-block data cache controller that issues BusRd/BusRdX transactions to `memory_control` and answers its snoops. It is the responder end of the `cctrans`/`ccwrite`/`ccwait`/`ccsnoopaddr`/`ccinv` protocol and the data initiator on `dREN`/`dWEN`/`dwait`. One instance per core sits between the datapath's dmem port and one slot of `cache_control_if`.

## Interface
- CPUID, 0, slot index this instance drives in `cache_control_if`.
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- dmemREN  in  1  datapath load request.
- dmemWEN  in  1  datapath store request (never together with dmemREN).
- dmemaddr  in  32  word address; [1:0] ignored, [5:2] index, [31:6] tag.
- dmemstore  in  32  store data.
- dmemload  out  32  load data, valid when dhit=1.
- dhit  out  1  request completed this cycle.
- dREN, dWEN  out  1  memory read / write request.
- daddr, dstore  out  32  memory address / write data.
- dload  in  32  memory or cache-to-cache read data.
- dwait  in  1  1 = transfer not yet accepted.
- cctrans  out  1  coherence transaction in progress.
- ccwrite  out  1  with cctrans: 1 = BusRdX, 0 = BusRd.
- ccwait  in  1  snoop pending; this agent must respond.
- ccsnoopaddr  in  32  snooped address.
- ccinv  in  1  with ccwait: invalidate snooped block.

## Operation
- Frame: {msi (I/S/M), tag[25:0], data[31:0]}; hit = msi!=I and tag match.
- States: IDLE, SNOOP, SNOOP_WB, EVICT, FETCH.
- IDLE, ccwait=1: -> SNOOP (takes priority over a pending datapath request).
- IDLE, read hit (S/M) or write hit in M: dhit=1 combinationally; store updates data, msi=M at next edge.
- IDLE, miss or write hit in S: victim in M and tag differs -> EVICT, else -> FETCH.
- EVICT: dWEN=1, daddr={victim tag,index,00}, dstore=victim data; on dwait=0 -> FETCH, victim msi=I.
- FETCH: cctrans=1, ccwrite=dmemWEN, dREN=1, daddr=dmemaddr; on dwait=0 fill frame with dload (store: merge dmemstore), msi = dmemWEN ? M : S, -> IDLE; the request then hits next cycle.
- SNOOP (one cycle, lookup ccsnoopaddr): hit in M -> SNOOP_WB; hit in S -> msi = ccinv ? I : S, -> IDLE; miss -> IDLE. No dWEN in SNOOP.
- SNOOP_WB: dWEN=1, daddr=ccsnoopaddr, dstore=frame data; on dwait=0 -> IDLE, msi = ccinv at SNOOP entry ? I : S.
- ccinv captured on SNOOP entry; later changes ignored.
- ccwait is honored only in IDLE; the controller never snoops an agent with cctrans=1.

## Timing
- Reset: all frames msi=I; state IDLE; every output 0.
- Reset mid-transaction: outputs drop immediately, frames invalidated, any M data lost.
- Hit latency 0 cycles; clean miss = 1 (IDLE) + FETCH dwait cycles; dirty miss adds EVICT.
- Snoop response: dWEN rises the cycle after SNOOP (2 cycles after ccwait first sampled), within the controller's 3-cycle snoop window; no dWEN in that window means "no supply".
- dWEN/dREN/cctrans held stable until the first edge with dwait=0, then deasserted next cycle.
- dhit never asserted in SNOOP, SNOOP_WB, EVICT, FETCH.
- Same-index snoop and local request: snoop completes first; local request re-evaluated in IDLE.

## Structure
- Add to cpu_types_pkg: msi_t enum {MSI_I, MSI_S, MSI_M}; coh_agent_state_t; coh_frame_t struct; localparams DIDX_W=4, DTAG_W=26.
- Sub-module coh_frame_array: 16-entry register file, one lookup port for dmemaddr, one for ccsnoopaddr, one write port, async-reset invalidate.

## Test plan
- Read 0x100 after reset, dwait low 2 cycles later -> FETCH, cctrans=1, ccwrite=0, fill 0xCAFE0001 msi=S, dhit next cycle with dmemload=0xCAFE0001.
- Store 0xDEAD to 0x100 in S -> FETCH with ccwrite=1, msi=M; subsequent read returns 0xDEAD with 0-cycle dhit.
- Store to 0x140 (same index, M victim 0x100) -> EVICT dWEN=1 daddr=0x100 dstore=0xDEAD, then FETCH daddr=0x140.
- 0x100 in M, ccwait=1 ccsnoopaddr=0x100 ccinv=0 -> dWEN two cycles later, dstore=0xDEAD, msi=S; repeat with ccinv=1 -> msi=I, next read misses.
- Snoop 0x200 (miss) and snoop of S line with ccinv=1 -> no dWEN for 3 cycles; S line becomes I.
- nRST low during FETCH -> all outputs 0 same cycle, prior hit on 0x100 now misses.
